// File: rtl/plab3_mem_cacheline_serializer_pkg.sv
// Memory message type encodings (vc-mem-msgs compatible) and serializer FSM states.
package plab3_mem_cacheline_serializer_pkg;

  localparam logic [1:0] MEM_TYPE_READ       = 2'd0;
  localparam logic [1:0] MEM_TYPE_WRITE      = 2'd1;
  localparam logic [1:0] MEM_TYPE_WRITE_INIT = 2'd2;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_REQ  = 2'd1;
  localparam logic [1:0] STATE_WAIT = 2'd2;
  localparam logic [1:0] STATE_RESP = 2'd3;

  // Anything that is not a write flavour (including the unknown code 3) is a read.
  function automatic logic is_write_type(input logic [1:0] t);
    return (t == MEM_TYPE_WRITE) || (t == MEM_TYPE_WRITE_INIT);
  endfunction

endpackage

// File: rtl/plab3_mem_cacheline_serializer_ctrl.sv
// Serializer control: IDLE/REQ/WAIT/RESP FSM with one word outstanding, plus word counter.
module plab3_mem_cacheline_serializer_ctrl
  import plab3_mem_cacheline_serializer_pkg::*;
#(
  parameter int nwords = 4,
  parameter int cntw   = (nwords > 1) ? $clog2(nwords) : 1
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            linereq_val,
  input  logic            wordreq_rdy,
  input  logic            wordresp_val,
  input  logic            lineresp_rdy,
  output logic            linereq_rdy,
  output logic            wordreq_val,
  output logic            wordresp_rdy,
  output logic            lineresp_val,
  output logic            line_go,
  output logic            word_go,
  output logic [cntw-1:0] cnt
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last;

  assign last = (cnt == cntw'(nwords - 1));

  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE: if (linereq_val)  state_next = STATE_REQ;
      STATE_REQ:  if (wordreq_rdy)  state_next = STATE_WAIT;
      STATE_WAIT: if (wordresp_val) state_next = last ? STATE_RESP : STATE_REQ;
      STATE_RESP: if (lineresp_rdy) state_next = STATE_IDLE;
      default:                      state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STATE_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (line_go)
        cnt <= '0;
      else if (word_go && !last)
        cnt <= cnt + cntw'(1);
    end
  end

  // Moore outputs: each handshake signal belongs to exactly one state.
  assign linereq_rdy  = (state == STATE_IDLE);
  assign wordreq_val  = (state == STATE_REQ);
  assign wordresp_rdy = (state == STATE_WAIT);
  assign lineresp_val = (state == STATE_RESP);

  assign line_go = linereq_val  && linereq_rdy;
  assign word_go = wordresp_val && wordresp_rdy;

endmodule

// File: rtl/plab3_mem_cacheline_serializer.sv
// Cacheline-to-word memory serializer: splits one line request into nwords word
// transactions and returns a single reassembled line response.
module plab3_mem_cacheline_serializer
  import plab3_mem_cacheline_serializer_pkg::*;
#(
  parameter int abw = 32,
  parameter int dbw = 32,
  parameter int clw = 128
)(
  input  logic           clk,
  input  logic           reset,

  input  logic           linereq_val,
  output logic           linereq_rdy,
  input  logic [1:0]     linereq_type,
  input  logic [abw-1:0] linereq_addr,
  input  logic [clw-1:0] linereq_data,

  output logic           lineresp_val,
  input  logic           lineresp_rdy,
  output logic [1:0]     lineresp_type,
  output logic [clw-1:0] lineresp_data,

  output logic           wordreq_val,
  input  logic           wordreq_rdy,
  output logic [1:0]     wordreq_type,
  output logic [abw-1:0] wordreq_addr,
  output logic [dbw-1:0] wordreq_data,

  input  logic           wordresp_val,
  output logic           wordresp_rdy,
  input  logic [dbw-1:0] wordresp_data
);

  localparam int nwords = clw / dbw;
  localparam int cntw   = (nwords > 1) ? $clog2(nwords) : 1;
  localparam int lbw    = $clog2(clw / 8);
  localparam int wbytes = dbw / 8;

  if (clw % dbw != 0) begin : g_bad_clw
    $error("clw must be an integer multiple of dbw");
  end

  logic            line_go;
  logic            word_go;
  logic [cntw-1:0] cnt;
  logic [1:0]      type_r;
  logic [abw-1:0]  base_r;
  logic [clw-1:0]  wdata_r;
  logic [clw-1:0]  rbuf_r;
  logic [abw-1:0]  word_addr;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^linereq_addr[lbw-1:0];

  plab3_mem_cacheline_serializer_ctrl #(
    .nwords (nwords),
    .cntw   (cntw)
  ) ctrl (
    .clk          (clk),
    .reset        (reset),
    .linereq_val  (linereq_val),
    .wordreq_rdy  (wordreq_rdy),
    .wordresp_val (wordresp_val),
    .lineresp_rdy (lineresp_rdy),
    .linereq_rdy  (linereq_rdy),
    .wordreq_val  (wordreq_val),
    .wordresp_rdy (wordresp_rdy),
    .lineresp_val (lineresp_val),
    .line_go      (line_go),
    .word_go      (word_go),
    .cnt          (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_r  <= MEM_TYPE_READ;
      base_r  <= '0;
      wdata_r <= '0;
      rbuf_r  <= '0;
    end else begin
      if (line_go) begin
        type_r  <= linereq_type;
        base_r  <= {linereq_addr[abw-1:lbw], {lbw{1'b0}}};
        wdata_r <= linereq_data;
      end
      if (word_go && !is_write_type(type_r))
        rbuf_r[cnt*dbw +: dbw] <= wordresp_data;
    end
  end

  // Word offset wraps at abw bits; the base is line-aligned so a line never straddles.
  assign word_addr = base_r + abw'(wbytes) * abw'(cnt);

  assign wordreq_addr  = wordreq_val ? word_addr : '0;
  assign wordreq_data  = wordreq_val ? wdata_r[cnt*dbw +: dbw] : '0;
  assign wordreq_type  = (wordreq_val && is_write_type(type_r)) ? MEM_TYPE_WRITE : MEM_TYPE_READ;

  assign lineresp_type = lineresp_val ? type_r : 2'd0;
  assign lineresp_data = (lineresp_val && !is_write_type(type_r)) ? rbuf_r : '0;

endmodule
